// File: rtl/mult_seq_ctrl.sv
// Byte-serial operand collector and result serializer in front of a multiplier core.
// Two operand bytes in, one start pulse, bounded wait for done, product out low byte first.
module mult_seq_ctrl #(
  parameter  int W       = 8,
  parameter  int TIMEOUT = 64,
  localparam int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   in_data,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  output logic           mul_start,
  input  logic           mul_done,
  input  logic [2*W-1:0] mul_p,
  output logic           busy,
  output logic           err
);

  typedef enum logic [2:0] {
    S_A,
    S_B,
    S_START,
    S_WAIT,
    S_LO,
    S_HI
  } state_t;

  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

  state_t         state_reg;
  logic [CW-1:0]  count_reg;
  logic [2*W-1:0] product_reg;
  logic [W-1:0]   mul_a_reg;
  logic [W-1:0]   mul_b_reg;
  logic           err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_A;
      count_reg   <= '0;
      product_reg <= '0;
      mul_a_reg   <= '0;
      mul_b_reg   <= '0;
      err_reg     <= 1'b0;
    end else begin
      case (state_reg)
        S_A: begin
          if (in_valid) begin
            mul_a_reg <= in_data;
            err_reg   <= 1'b0;
            state_reg <= S_B;
          end
        end
        S_B: begin
          if (in_valid) begin
            mul_b_reg <= in_data;
            state_reg <= S_START;
          end
        end
        S_START: begin
          // A done seen here belongs to an earlier operation and is dropped.
          count_reg <= '0;
          state_reg <= S_WAIT;
        end
        S_WAIT: begin
          if (mul_done) begin
            product_reg <= mul_p;
            state_reg   <= S_LO;
          end else if (count_reg == LAST_WAIT) begin
            product_reg <= '1;
            err_reg     <= 1'b1;
            state_reg   <= S_LO;
          end else begin
            count_reg <= count_reg + CW'(1);
          end
        end
        S_LO: begin
          if (out_ready) state_reg <= S_HI;
        end
        S_HI: begin
          if (out_ready) state_reg <= S_A;
        end
        default: state_reg <= S_A;
      endcase
    end
  end

  // Handshake flags are forced low while reset is held, whatever the state.
  assign in_ready  = !rst && (state_reg == S_A || state_reg == S_B);
  assign out_valid = !rst && (state_reg == S_LO || state_reg == S_HI);
  assign mul_start = !rst && (state_reg == S_START);
  assign busy      = !rst && (state_reg != S_A);

  assign out_data = (state_reg == S_HI) ? product_reg[2*W-1:W] : product_reg[W-1:0];
  assign mul_a    = mul_a_reg;
  assign mul_b    = mul_b_reg;
  assign err      = err_reg;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl: a small core model, a byte scoreboard
// filled when operands are driven and drained on each output transfer.
module tb_mult_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic        mul_start;
  logic        mul_done;
  logic [15:0] mul_p;
  logic        busy;
  logic        err;

  mult_seq_ctrl #(.W(8), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start),
    .mul_done(mul_done), .mul_p(mul_p),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       err;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // Core model settings, driven by the stimulus sequence.
  logic core_auto  = 1'b1;
  int   core_delay = 3;
  int   core_cd    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns the number of cycles until out_valid is seen (bounded).
  task automatic wait_out(input int bound, output int n);
    n = 0;
    while (!out_valid && n < bound) begin
      tick();
      n++;
    end
    if (!out_valid) chk("wait_out_timeout", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) chk("drain_timeout", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic send(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic expect_bytes(input logic [7:0] lo, input logic [7:0] hi, input logic e);
    q.push_back('{data: lo, err: e});
    q.push_back('{data: hi, err: e});
  endtask

  // Core model: done pulses core_delay cycles after the start cycle.
  always @(posedge clk) begin
    #1;
    if (core_auto) begin
      if (mul_start) begin
        core_cd  = core_delay;
        mul_p    = 16'(mul_a) * 16'(mul_b);
        mul_done = 1'b0;
      end else if (core_cd > 0) begin
        core_cd--;
        mul_done = (core_cd == 0);
      end else begin
        mul_done = 1'b0;
      end
    end
  end

  // Output monitor: every accepted byte is checked against the scoreboard.
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_byte", {24'd0, out_data}, 32'hFFFF_FFFF);
      end else begin
        e = q.pop_front();
        chk("out_byte", {24'd0, out_data}, {24'd0, e.data});
        chk("out_err", {31'd0, err}, {31'd0, e.err});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    mul_done  = 1'b0;
    mul_p     = 16'h0000;

    // Reset state
    tick();
    tick();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mul_start", {31'd0, mul_start}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_mul_a", {24'd0, mul_a}, 32'd0);
    chk("rst_mul_b", {24'd0, mul_b}, 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // 1: 0x0C * 0x0D, done 3 cycles after start
    core_auto  = 1'b1;
    core_delay = 3;
    send(8'h0C);
    chk("t1_busy_b", {31'd0, busy}, 32'd1);
    send(8'h0D);
    expect_bytes(8'h9C, 8'h00, 1'b0);
    chk("t1_start", {31'd0, mul_start}, 32'd1);
    chk("t1_mul_a", {24'd0, mul_a}, 32'h0C);
    chk("t1_mul_b", {24'd0, mul_b}, 32'h0D);
    wait_out(200, n);
    chk("t1_latency", n, 32'd4);
    tick();
    chk("t1_hi_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("t1_back_in_ready", {31'd0, in_ready}, 32'd1);

    // 2: 0xFF * 0xFF with consumer stalled in the low byte
    out_ready = 1'b0;
    send(8'hFF);
    send(8'hFF);
    expect_bytes(8'h01, 8'hFE, 1'b0);
    wait_out(200, n);
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_data", {24'd0, out_data}, 32'h01);
      chk("t2_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("t2_hold_busy", {31'd0, busy}, 32'd1);
      chk("t2_hold_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    tick();
    chk("t2_hi_busy", {31'd0, busy}, 32'd1);
    chk("t2_hi_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("t2_back_in_ready", {31'd0, in_ready}, 32'd1);

    // 3: core never answers -> timeout after exactly 64 wait cycles
    core_auto = 1'b0;
    mul_done  = 1'b0;
    send(8'h10);
    send(8'h20);
    expect_bytes(8'hFF, 8'hFF, 1'b1);
    wait_out(200, n);
    chk("t3_wait_cycles", n - 1, 32'd64);
    chk("t3_err", {31'd0, err}, 32'd1);
    drain();
    chk("t3_err_sticky", {31'd0, err}, 32'd1);
    core_auto  = 1'b1;
    core_delay = 2;
    send(8'h02);
    chk("t3_err_cleared", {31'd0, err}, 32'd0);
    send(8'h03);
    expect_bytes(8'h06, 8'h00, 1'b0);
    wait_out(200, n);
    drain();

    // 4: done held through START and first WAIT cycle
    core_auto = 1'b0;
    mul_done  = 1'b0;
    send(8'h11);
    chk("t4_no_start_b", {31'd0, mul_start}, 32'd0);
    send(8'h22);
    expect_bytes(8'h34, 8'h12, 1'b0);
    mul_done = 1'b1;
    mul_p    = 16'h1234;
    chk("t4_start", {31'd0, mul_start}, 32'd1);
    tick();
    chk("t4_start_once", {31'd0, mul_start}, 32'd0);
    chk("t4_wait_no_valid", {31'd0, out_valid}, 32'd0);
    tick();
    mul_done = 1'b0;
    mul_p    = 16'h0000;
    chk("t4_valid", {31'd0, out_valid}, 32'd1);
    drain();

    // 5: reset while waiting, late done must be ignored
    send(8'h05);
    send(8'h06);
    tick();
    tick();
    chk("t5_waiting", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    chk("t5_rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    chk("t5_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_mul_a", {24'd0, mul_a}, 32'd0);
    chk("t5_mul_b", {24'd0, mul_b}, 32'd0);
    rst      = 1'b0;
    mul_done = 1'b1;
    mul_p    = 16'hABCD;
    #1;
    chk("t5_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    mul_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t5_no_valid", {31'd0, out_valid}, 32'd0);
      chk("t5_idle", {31'd0, in_ready}, 32'd1);
      tick();
    end

    // 6: in_valid gaps between operand bytes
    core_auto  = 1'b1;
    core_delay = 2;
    send(8'h07);
    in_valid = 1'b0;
    in_data  = 8'hEE;
    tick();
    chk("t6_still_b", {31'd0, in_ready}, 32'd1);
    send(8'h09);
    expect_bytes(8'h3F, 8'h00, 1'b0);
    chk("t6_start", {31'd0, mul_start}, 32'd1);
    chk("t6_mul_a", {24'd0, mul_a}, 32'h07);
    chk("t6_mul_b", {24'd0, mul_b}, 32'h09);
    wait_out(200, n);
    drain();

    tick();
    chk("scoreboard_empty", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
